// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//   Serialises parallel words onto a single UART line. Each frame is one
//   start bit (0), then DATA_BITS data bits LSB first, then STOP_BITS stop
//   bits (1). Each serial bit lasts CLKS_PER_BIT clocks. When a new word is
//   accepted on the final clock of the last stop bit, the next start bit
//   follows with no idle gap.
//
//   Ports
//     clk      in   1          system clock, rising edge
//     rst      in   1          asynchronous active-high reset
//     txData   in   DATA_BITS  word to send; captured on the accepting edge
//     txValid  in   1          producer has txData available
//     txReady  out  1          transmitter accepts a word this cycle
//     txOut    out  1          serial line, idles high, driven from a flop
//     busy     out  1          frame in flight (START/DATA/STOP)
//     done     out  1          pulse on the final clock of the last stop bit
//
//   state | meaning
//   IDLE  | line high, waiting for txValid
//   START | start bit (0) on the line
//   DATA  | data bits, LSB first, from the shift register
//   STOP  | stop bit(s) (1); the final clock may accept the next word
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] txData,
    input  logic                 txValid,
    output logic                 txReady,
    output logic                 txOut,
    output logic                 busy,
    output logic                 done
);

    localparam int BW = ($clog2(CLKS_PER_BIT + 1) < 1) ? 1 : $clog2(CLKS_PER_BIT + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [BW-1:0]        baud_cnt;
    logic [2:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 tx_q;

    logic bit_end;
    logic last_stop;
    logic accept;

    // With CLKS_PER_BIT=1 baud_cnt never leaves 0 and every clock ends a bit.
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign last_stop = (state == STOP) && bit_end && (stop_cnt == STOP_LAST);
    assign txReady   = (state == IDLE) || last_stop;
    assign accept    = txValid && txReady;
    assign busy      = (state != IDLE);
    assign done      = last_stop;
    assign txOut     = tx_q;

    // tx_q is loaded with the level of the bit that the next state will
    // present, so the line stays aligned with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (accept) begin
                        shift <= txData;
                        state <= START;
                        tx_q  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                        tx_q     <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                            tx_q     <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            if (accept) begin
                                shift <= txData;
                                state <= START;
                                tx_q  <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

    localparam int CPB [3] = '{1, 4, 2};
    localparam int SB  [3] = '{1, 1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data  [3];
    logic       valid [3];
    logic       ready [3];
    logic       out   [3];
    logic       busy  [3];
    logic       done  [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(1), .DATA_BITS(8), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .txData(data[0]), .txValid(valid[0]),
        .txReady(ready[0]), .txOut(out[0]), .busy(busy[0]), .done(done[0]));
    uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .txData(data[1]), .txValid(valid[1]),
        .txReady(ready[1]), .txOut(out[1]), .busy(busy[1]), .done(done[1]));
    uart_transmitter #(.CLKS_PER_BIT(2), .DATA_BITS(8), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .txData(data[2]), .txValid(valid[2]),
        .txReady(ready[2]), .txOut(out[2]), .busy(busy[2]), .done(done[2]));

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    // Level of serial bit number idx of a frame carrying b (0 = start bit).
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    // Reference model: each instance is either idle or at clock position pos
    // of a frame of (1+8+SB)*CPB clocks. Checked on every falling edge.
    bit         m_act  [3];
    int         m_pos  [3];
    logic [7:0] m_byte [3];

    initial for (int i = 0; i < 3; i++) begin
        m_act[i] = 0; m_pos[i] = 0; m_byte[i] = 8'h00;
    end

    always @(negedge clk) begin : model
        int   flen;
        logic eo, eb, ed, er;
        for (int i = 0; i < 3; i++) begin
            flen = (1 + 8 + SB[i]) * CPB[i];
            if (rst) begin
                m_act[i] = 0;
                m_pos[i] = 0;
            end
            if (m_act[i]) begin
                eo = frame_bit(m_byte[i], m_pos[i] / CPB[i]);
                eb = 1'b1;
                ed = (m_pos[i] == flen - 1);
                er = ed;
            end else begin
                eo = 1'b1; eb = 1'b0; ed = 1'b0; er = 1'b1;
            end
            check("model{out,busy,done,ready}", i,
                  {28'd0, out[i], busy[i], done[i], ready[i]}, {28'd0, eo, eb, ed, er});
            if (!rst) begin
                if (valid[i] && er) begin
                    m_act[i]  = 1;
                    m_pos[i]  = 0;
                    m_byte[i] = data[i];
                end else if (m_act[i]) begin
                    if (m_pos[i] == flen - 1) m_act[i] = 0;
                    else m_pos[i]++;
                end
            end
        end
    end

    typedef struct {
        int         inst;
        logic [7:0] d0;
        logic [7:0] d1;
        bit         b2b;
        string      line;
    } vec_t;

    vec_t vecs [5];

    // Sends one frame (or two back-to-back) and compares the line clock by clock.
    task automatic send(input vec_t v);
        int n;
        bit last;
        n = v.line.len();
        @(posedge clk); #2;
        data[v.inst]  = v.d0;
        valid[v.inst] = 1'b1;
        @(posedge clk); #2;
        if (v.b2b) data[v.inst] = v.d1;
        else begin
            valid[v.inst] = 1'b0;
            data[v.inst]  = 8'($urandom);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            last = (k == n - 1) || (v.b2b && k == n / 2 - 1);
            check("vec_txOut", v.inst, {31'd0, out[v.inst]}, {31'd0, v.line[k] == 8'h31});
            check("vec_done", v.inst, {31'd0, done[v.inst]}, {31'd0, last});
            check("vec_txReady", v.inst, {31'd0, ready[v.inst]}, {31'd0, last});
            if (v.b2b && k == n / 2 - 1) begin
                @(posedge clk); #2;
                valid[v.inst] = 1'b0;
                data[v.inst]  = 8'($urandom);
            end
        end
        @(posedge clk); #2;
    endtask

    initial begin
        vecs[0] = '{inst: 0, d0: 8'hA5, d1: 8'h00, b2b: 0, line: "0101001011"};
        vecs[1] = '{inst: 1, d0: 8'h00, d1: 8'h00, b2b: 0,
                    line: "0000000000000000000000000000000000001111"};
        vecs[2] = '{inst: 2, d0: 8'hFF, d1: 8'h00, b2b: 0, line: "0011111111111111111111"};
        vecs[3] = '{inst: 0, d0: 8'h3C, d1: 8'hC3, b2b: 1, line: "00011110010110000111"};
        vecs[4] = '{inst: 0, d0: 8'h81, d1: 8'h00, b2b: 0, line: "0100000011"};
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end

        // Asynchronous reset between edges: outputs settle with no clock edge.
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            check("reset_async", i, {28'd0, out[i], busy[i], done[i], ready[i]}, 32'b1001);
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 4; v++) send(vecs[v]);

        // Abort 8'h55 during data bit 3 (bit 3 is 0, so the jump to 1 is visible).
        @(posedge clk); #2;
        data[0] = 8'h55; valid[0] = 1'b1;
        @(posedge clk); #2;
        valid[0] = 1'b0; data[0] = 8'h00;
        repeat (5) @(negedge clk);
        check("abort_pre_line", 0, {31'd0, out[0]}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("abort_reset", 0, {28'd0, out[0], busy[0], done[0], ready[0]}, 32'b1001);
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        send(vecs[4]);

        // Randomised traffic with occasional reset pulses; the model checks it.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 3; i++) begin
                valid[i] = ($urandom_range(0, 3) != 0);
                data[i]  = 8'($urandom);
            end
        end
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) valid[i] = 1'b0;
        repeat (60) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++)
            check("final_idle", i, {28'd0, out[i], busy[i], done[i], ready[i]}, 32'b1001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
